// File: rtl/usb_tx_pkg.sv
// Shared constants and state encoding for the non-data packet TX sequencer.
package usb_tx_pkg;

    localparam logic [7:0] SYNC_BYTE = 8'h80;

    typedef enum logic [2:0] {
        IDLE = 3'd0,
        SYNC = 3'd1,
        DATA = 3'd2,
        EOP  = 3'd3,
        GAP  = 3'd4
    } nd_seq_state_t;

endpackage

// File: rtl/nd_tx_sequencer_gap_timer.sv
// Inter-packet gap timer: loads GAP_CYCLES-1, counts down to zero and holds there.
module nd_gap_timer #(
    parameter int GAP_CYCLES = 16
) (
    input  logic clk,
    input  logic n_rst,
    input  logic load_i,
    input  logic dec_i,
    output logic zero_o
);

    localparam int GW = (GAP_CYCLES > 1) ? $clog2(GAP_CYCLES) : 1;
    localparam logic [GW-1:0] LOAD_VAL = GW'(GAP_CYCLES - 1);

    logic [GW-1:0] cnt_q, cnt_d;

    always_comb begin
        cnt_d = cnt_q;
        if (load_i) begin
            cnt_d = LOAD_VAL;
        end else if (dec_i && (cnt_q != '0)) begin
            cnt_d = cnt_q - GW'(1);
        end
    end

    always_ff @(posedge clk or negedge n_rst) begin
        if (!n_rst) begin
            cnt_q <= '0;
        end else begin
            cnt_q <= cnt_d;
        end
    end

    assign zero_o = (cnt_q == '0);

endmodule

// File: rtl/nd_tx_sequencer.sv
// Drains one token/handshake packet from nd_fifo, prefixes SYNC, requests EOP,
// then enforces the inter-packet gap before the next start is accepted.
module nd_tx_sequencer
    import usb_tx_pkg::*;
#(
    parameter int MAX_BYTES  = 200,
    parameter int GAP_CYCLES = 16,
    parameter int CNT_W      = 8
) (
    input  logic             clk,
    input  logic             n_rst,
    input  logic             tx_start,
    input  logic             fifo_empty,
    input  logic [7:0]       fifo_r_data,
    output logic             fifo_r_enable,
    output logic [7:0]       tx_byte,
    output logic             tx_valid,
    input  logic             tx_ready,
    output logic             eop_req,
    input  logic             eop_done,
    output logic             busy,
    output logic             tx_done,
    output logic             start_err,
    output logic             overlong,
    output logic [CNT_W-1:0] pkt_bytes,
    output nd_seq_state_t    state_dbg_o
);

    localparam logic [CNT_W-1:0] MAX_CNT = CNT_W'(MAX_BYTES);

    nd_seq_state_t    state_q, state_d;
    logic [CNT_W-1:0] pkt_bytes_q, pkt_bytes_d;
    logic             overlong_q, overlong_d;
    logic             tx_done_q, tx_done_d;
    logic             start_err_q, start_err_d;
    logic             gap_load, gap_zero, data_ok;

    assign data_ok = !fifo_empty && (pkt_bytes_q < MAX_CNT);

    // Handshake: a byte transfers on a clock edge where tx_valid & tx_ready are
    // both high; once raised, tx_valid and tx_byte hold until that edge, and the
    // fifo pop is that same handshake so the FWFT head is consumed exactly once.
    always_comb begin
        tx_byte       = 8'h00;
        tx_valid      = 1'b0;
        fifo_r_enable = 1'b0;
        eop_req       = 1'b0;
        case (state_q)
            SYNC: begin
                tx_byte  = SYNC_BYTE;
                tx_valid = 1'b1;
            end
            DATA: begin
                if (data_ok) begin
                    tx_byte       = fifo_r_data;
                    tx_valid      = 1'b1;
                    fifo_r_enable = tx_ready;
                end
            end
            EOP:     eop_req = 1'b1;
            default: ;
        endcase
    end

    always_comb begin
        state_d     = state_q;
        pkt_bytes_d = pkt_bytes_q;
        overlong_d  = overlong_q;
        tx_done_d   = 1'b0;
        start_err_d = 1'b0;
        gap_load    = 1'b0;
        case (state_q)
            IDLE: begin
                if (tx_start) begin
                    if (fifo_empty) begin
                        start_err_d = 1'b1;
                    end else begin
                        state_d     = SYNC;
                        pkt_bytes_d = '0;
                        overlong_d  = 1'b0;
                    end
                end
            end
            SYNC: if (tx_ready) state_d = DATA;
            DATA: begin
                if (fifo_empty) begin
                    state_d = EOP;
                end else if (!data_ok) begin
                    // Cap reached with bytes still queued: truncate, leave them in the fifo.
                    overlong_d = 1'b1;
                    state_d    = EOP;
                end else if (tx_ready) begin
                    pkt_bytes_d = pkt_bytes_q + CNT_W'(1);
                end
            end
            EOP: begin
                if (eop_done) begin
                    state_d  = GAP;
                    gap_load = 1'b1;
                end
            end
            GAP: begin
                if (gap_zero) begin
                    state_d   = IDLE;
                    tx_done_d = 1'b1;
                end
            end
            default: state_d = IDLE;
        endcase
    end

    always_ff @(posedge clk or negedge n_rst) begin
        if (!n_rst) begin
            state_q     <= IDLE;
            pkt_bytes_q <= '0;
            overlong_q  <= 1'b0;
            tx_done_q   <= 1'b0;
            start_err_q <= 1'b0;
        end else begin
            state_q     <= state_d;
            pkt_bytes_q <= pkt_bytes_d;
            overlong_q  <= overlong_d;
            tx_done_q   <= tx_done_d;
            start_err_q <= start_err_d;
        end
    end

    nd_gap_timer #(
        .GAP_CYCLES(GAP_CYCLES)
    ) u_gap_timer (
        .clk   (clk),
        .n_rst (n_rst),
        .load_i(gap_load),
        .dec_i (state_q == GAP),
        .zero_o(gap_zero)
    );

    assign busy        = (state_q != IDLE);
    assign tx_done     = tx_done_q;
    assign start_err   = start_err_q;
    assign overlong    = overlong_q;
    assign pkt_bytes   = pkt_bytes_q;
    assign state_dbg_o = state_q;

endmodule

// File: tb/tb_nd_tx_sequencer.sv
// Directed + randomized bench for nd_tx_sequencer with a fifo model, a serializer
// responder and a packet-level reference model.
module tb_nd_tx_sequencer;

    localparam int MAXB = 200;
    localparam int GAPC = 16;

    logic       clk = 1'b0;
    logic       n_rst = 1'b0;
    logic       tx_start = 1'b0;
    logic       fifo_empty;
    logic [7:0] fifo_r_data;
    logic       fifo_r_enable;
    logic [7:0] tx_byte;
    logic       tx_valid;
    logic       tx_ready = 1'b0;
    logic       eop_req;
    logic       eop_done = 1'b0;
    logic       busy, tx_done, start_err, overlong;
    logic [7:0] pkt_bytes;
    logic [2:0] state_dbg;

    always #5 clk = ~clk;

    nd_tx_sequencer #(
        .MAX_BYTES(MAXB), .GAP_CYCLES(GAPC), .CNT_W(8)
    ) dut (
        .clk(clk), .n_rst(n_rst), .tx_start(tx_start), .fifo_empty(fifo_empty),
        .fifo_r_data(fifo_r_data), .fifo_r_enable(fifo_r_enable), .tx_byte(tx_byte),
        .tx_valid(tx_valid), .tx_ready(tx_ready), .eop_req(eop_req), .eop_done(eop_done),
        .busy(busy), .tx_done(tx_done), .start_err(start_err), .overlong(overlong),
        .pkt_bytes(pkt_bytes), .state_dbg_o(state_dbg)
    );

    // FWFT fifo model
    logic [7:0]  mem [0:511];
    int unsigned rd_ptr = 0;
    int unsigned wr_ptr = 0;
    assign fifo_empty  = (rd_ptr == wr_ptr);
    assign fifo_r_data = mem[rd_ptr[8:0]];

    int         cyc = 0, stab_err = 0, serr_cnt = 0;
    int         e_cnt = 0, e_cyc = 0, spur_cnt = 0, spur_seen = 0, eop_wait = 2;
    int         ready_mode = 0;
    logic       held = 1'b0;
    logic [7:0] held_byte = 8'h00;
    logic [7:0] got_q[$];
    logic [7:0] model_q[$];
    logic [7:0] exp_q[$];
    int         n_assert = 0, n_fail = 0;

    always @(posedge clk) begin
        cyc <= cyc + 1;
        if (n_rst) begin
            if (tx_valid && tx_ready) got_q.push_back(tx_byte);
            if (held && !(tx_valid && tx_byte == held_byte)) stab_err <= stab_err + 1;
            held      <= tx_valid && !tx_ready;
            held_byte <= tx_byte;
            if (fifo_r_enable) rd_ptr <= rd_ptr + 1;
            if (start_err) serr_cnt <= serr_cnt + 1;
        end else begin
            held <= 1'b0;
        end
    end

    // Serializer responder: ready pattern plus EOP completion after a random delay.
    always @(negedge clk) begin
        case (ready_mode)
            0:       tx_ready <= 1'b1;
            1:       tx_ready <= !tx_ready;
            default: tx_ready <= 1'($urandom_range(0, 1));
        endcase
        if (eop_done) begin
            eop_done <= 1'b0;
        end else if (spur_cnt != spur_seen) begin
            eop_done  <= 1'b1;
            spur_seen <= spur_cnt;
        end else if (eop_req) begin
            if (eop_wait == 0) begin
                eop_done <= 1'b1;
                e_cyc    <= cyc;
                e_cnt    <= e_cnt + 1;
                eop_wait <= int'($urandom_range(1, 4));
            end else begin
                eop_wait <= eop_wait - 1;
            end
        end
    end

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_assert++;
        assert (obs === exp) else begin
            n_fail++;
            $error("FAIL %s: observed 0x%0h expected 0x%0h", tag, obs, exp);
        end
    endtask

    task automatic push_byte(input logic [7:0] b);
        mem[wr_ptr[8:0]] = b;
        wr_ptr = wr_ptr + 1;
        model_q.push_back(b);
    endtask

    // Send the fifo contents as one packet and check it against the packet model.
    task automatic run_pkt(input string tag, input int mode, input bit spur, input bit gap_start);
        int n, base, e0, serr0, k, t_done;
        bit done, spur_done, over_exp;
        n        = (model_q.size() > MAXB) ? MAXB : model_q.size();
        over_exp = (model_q.size() > MAXB);
        exp_q.delete();
        exp_q.push_back(8'h80);
        for (int i = 0; i < n; i++) exp_q.push_back(model_q[i]);
        base = got_q.size(); e0 = e_cnt; serr0 = serr_cnt; ready_mode = mode;
        @(negedge clk); tx_start = 1'b1;
        @(negedge clk); tx_start = 1'b0;
        chk({tag, " sync_valid"}, 32'(tx_valid), 1);
        chk({tag, " sync_byte"}, 32'(tx_byte), 32'h80);
        chk({tag, " busy_on"}, 32'(busy), 1);
        done = 0; spur_done = 0; k = 0; t_done = 0;
        for (int i = 0; i < 3000 && !done; i++) begin
            @(negedge clk);
            tx_start = 1'b0;
            if (tx_done) begin
                done = 1; t_done = cyc;
            end else begin
                if (spur && !spur_done && tx_valid && got_q.size() > base + 1) begin
                    spur_cnt++; spur_done = 1;
                end
                if (gap_start) begin
                    if (k == 0 && eop_req) begin
                        tx_start = 1'b1; k = 1;
                    end else if (k >= 1 && e_cnt != e0) begin
                        k++;
                        if (k == 5) tx_start = 1'b1;
                    end
                end
            end
        end
        chk({tag, " tx_done_seen"}, 32'(done), 1);
        chk({tag, " gap_len"}, 32'(t_done - e_cyc), 32'(GAPC + 1));
        chk({tag, " pkt_bytes"}, 32'(pkt_bytes), 32'(n));
        chk({tag, " overlong"}, 32'(overlong), 32'(over_exp));
        chk({tag, " busy_off"}, 32'(busy), 0);
        chk({tag, " byte_count"}, 32'(got_q.size() - base), 32'(n + 1));
        for (int i = 0; i < exp_q.size(); i++)
            chk($sformatf("%s byte%0d", tag, i), 32'(got_q[base + i]), 32'(exp_q[i]));
        for (int i = 0; i < n; i++) void'(model_q.pop_front());
        chk({tag, " fifo_left"}, wr_ptr - rd_ptr, 32'(model_q.size()));
        chk({tag, " fifo_empty"}, 32'(fifo_empty), 32'(model_q.size() == 0));
        chk({tag, " stable"}, 32'(stab_err), 0);
        @(negedge clk);
        chk({tag, " tx_done_pulse"}, 32'(tx_done), 0);
        chk({tag, " idle_after"}, 32'(busy), 0);
        chk({tag, " no_start_err"}, 32'(serr_cnt), 32'(serr0));
    endtask

    initial begin
        int base;
        int unsigned rp;
        // Reset state
        repeat (3) @(negedge clk);
        chk("rst tx_valid", 32'(tx_valid), 0);
        chk("rst tx_byte", 32'(tx_byte), 0);
        chk("rst busy", 32'(busy), 0);
        chk("rst flags", 32'({tx_done, start_err, overlong, eop_req, fifo_r_enable}), 0);
        chk("rst pkt_bytes", 32'(pkt_bytes), 0);
        chk("rst state", 32'(state_dbg), 0);
        n_rst = 1'b1;
        @(negedge clk);

        // 1: single handshake PID
        push_byte(8'hD2);
        run_pkt("t1", 0, 0, 0);

        // 2: token with ready toggling
        push_byte(8'h69); push_byte(8'h05); push_byte(8'hA8);
        run_pkt("t2", 1, 0, 0);

        // 3: start with empty fifo
        @(negedge clk); tx_start = 1'b1;
        @(negedge clk); tx_start = 1'b0;
        chk("t3 start_err", 32'(start_err), 1);
        chk("t3 busy", 32'(busy), 0);
        chk("t3 tx_valid", 32'(tx_valid), 0);
        @(negedge clk);
        chk("t3 start_err_pulse", 32'(start_err), 0);
        chk("t3 still_idle", 32'(busy), 0);

        // 4: overlong packet, random ready
        for (int i = 0; i < MAXB + 1; i++) push_byte(8'($urandom_range(0, 255)));
        run_pkt("t4", 2, 0, 0);

        // 5: reset mid-DATA after two payload bytes
        for (int i = 0; i < 6; i++) push_byte(8'($urandom_range(0, 255)));
        base = got_q.size(); ready_mode = 0;
        @(negedge clk); tx_start = 1'b1;
        @(negedge clk); tx_start = 1'b0;
        for (int i = 0; i < 50 && (got_q.size() - base) < 3; i++) @(negedge clk);
        chk("t5 two_bytes_sent", 32'(got_q.size() - base), 3);
        n_rst = 1'b0;
        #1;
        chk("t5 rst tx_valid", 32'(tx_valid), 0);
        chk("t5 rst busy", 32'(busy), 0);
        chk("t5 rst pop", 32'(fifo_r_enable), 0);
        chk("t5 rst eop_req", 32'(eop_req), 0);
        chk("t5 rst tx_byte", 32'(tx_byte), 0);
        chk("t5 rst pkt_bytes", 32'(pkt_bytes), 0);
        void'(model_q.pop_front()); void'(model_q.pop_front());
        rp = rd_ptr;
        repeat (3) @(negedge clk);
        chk("t5 no_pop_in_rst", rd_ptr, rp);
        chk("t5 fifo_left", wr_ptr - rd_ptr, 32'(model_q.size()));
        n_rst = 1'b1;
        @(negedge clk);
        chk("t5 idle_after_rst", 32'(busy), 0);
        chk("t5 no_valid_after_rst", 32'(tx_valid), 0);

        // 6: leftover bytes; spurious eop_done in DATA, tx_start in EOP and GAP
        run_pkt("t6", 1, 1, 1);
        push_byte(8'h4B);
        run_pkt("t6b", 0, 0, 0);

        $display("End of test - %0d assertions evaluated, %0d failures", n_assert, n_fail);
        $finish;
    end

endmodule
